// File: rtl/iobus_intr_pkg.sv
// Shared constants and helpers for the IOBUS interrupt controller.
// Register word offsets, STATUS layout, claim priority and popcount.
package iobus_intr_pkg;

  localparam int MAX_SRC = 31;

  localparam logic [2:0] OFF_PENDING  = 3'd0;
  localparam logic [2:0] OFF_ENABLE   = 3'd1;
  localparam logic [2:0] OFF_EDGE_SEL = 3'd2;
  localparam logic [2:0] OFF_CLAIM    = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  localparam int ST_INTR_BIT = 0;
  localparam int ST_CNT_LSB  = 8;
  localparam int ST_CNT_W    = 5;

  // Lowest active index plus one, zero when nothing is active.
  function automatic logic [ST_CNT_W-1:0] prio_claim(
    input logic [MAX_SRC-1:0] v
  );
    logic [ST_CNT_W-1:0] r;
    r = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = ST_CNT_W'(i + 1);
      end
    end
    return r;
  endfunction

  // Number of set bits; 31 sources always fit in five bits.
  function automatic logic [ST_CNT_W-1:0] popcnt(
    input logic [MAX_SRC-1:0] v
  );
    logic [ST_CNT_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_SRC; i++) begin
      r = r + ST_CNT_W'(v[i]);
    end
    return r;
  endfunction

endpackage

// File: rtl/iobus_intr_ctrl_sync.sv
// Two-flop synchronizer bank for asynchronous request lines.
// Output is the second stage; both stages reset to zero.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  // Capture then re-register to settle metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/iobus_intr_ctrl.sv
// Memory-mapped interrupt controller on the MCU IOBUS.
// Pends synchronized sources, masks them and drives a registered INTR.
module iobus_intr_ctrl
  import iobus_intr_pkg::*;
#(
  parameter int          N_SRC     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h1100_0200,
  parameter logic [N_SRC-1:0] EDGE_RST = {N_SRC{1'b1}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_SRC-1:0] SRC,
  input  logic [31:0]      IOBUS_ADDR,
  input  logic [31:0]      IOBUS_OUT,
  input  logic             IOBUS_WR,
  output logic [31:0]      IOBUS_IN,
  output logic             INTR
);

  logic [N_SRC-1:0] w_s2;
  logic [N_SRC-1:0] r_prev;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_en;
  logic [N_SRC-1:0] r_esel;
  logic             r_intr;

  logic             w_hit;
  logic [2:0]       w_off;
  logic             w_wr_pend;
  logic             w_wr_en;
  logic             w_wr_esel;
  logic             w_wr_claim;
  logic [N_SRC-1:0] w_claim_clr;
  logic [N_SRC-1:0] w_clr;
  logic [N_SRC-1:0] w_set;
  logic [N_SRC-1:0] w_pend_nxt;
  logic [N_SRC-1:0] w_en_nxt;
  logic [N_SRC-1:0] w_esel_nxt;
  logic [N_SRC-1:0] w_act;
  logic [MAX_SRC-1:0] w_act_x;
  logic [31:0]      w_status;
  logic             w_unused;

  sync_2ff #(
    .W (N_SRC)
  ) u_sync (
    .clk (CLK),
    .rst (RST),
    .i_d (SRC),
    .o_q (w_s2)
  );

  assign w_unused = ^IOBUS_ADDR[1:0];

  assign w_off = IOBUS_ADDR[4:2];
  assign w_hit = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5])
              && (w_off <= OFF_STATUS);

  assign w_wr_pend  = IOBUS_WR && w_hit && (w_off == OFF_PENDING);
  assign w_wr_en    = IOBUS_WR && w_hit && (w_off == OFF_ENABLE);
  assign w_wr_esel  = IOBUS_WR && w_hit && (w_off == OFF_EDGE_SEL);
  assign w_wr_claim = IOBUS_WR && w_hit && (w_off == OFF_CLAIM);

  // Claim value k in 1..N_SRC selects bit k-1; anything else is a no-op.
  always_comb begin
    w_claim_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_claim_clr[i] = w_wr_claim && (IOBUS_OUT == 32'(i + 1));
    end
  end

  // Edge sources fire on a fresh rise; level sources fire while high.
  assign w_set = w_s2 & ~(r_esel & r_prev);

  assign w_clr = (w_wr_pend ? IOBUS_OUT[N_SRC-1:0] : '0)
               | w_claim_clr;

  assign w_pend_nxt = (r_pend & ~w_clr) | w_set;
  assign w_en_nxt   = w_wr_en   ? IOBUS_OUT[N_SRC-1:0] : r_en;
  assign w_esel_nxt = w_wr_esel ? IOBUS_OUT[N_SRC-1:0] : r_esel;

  // Controller state; INTR looks ahead at the values being written.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_prev <= '0;
      r_pend <= '0;
      r_en   <= '0;
      r_esel <= EDGE_RST;
      r_intr <= 1'b0;
    end else begin
      r_prev <= w_s2;
      r_pend <= w_pend_nxt;
      r_en   <= w_en_nxt;
      r_esel <= w_esel_nxt;
      r_intr <= |(w_pend_nxt & w_en_nxt);
    end
  end

  assign w_act   = r_pend & r_en;
  assign w_act_x = MAX_SRC'(w_act);

  // STATUS word: request level and count of enabled pending sources.
  always_comb begin
    w_status = '0;
    w_status[ST_INTR_BIT] = r_intr;
    w_status[ST_CNT_LSB +: ST_CNT_W] = popcnt(w_act_x);
  end

  // Combinational read mux; reads never change state.
  always_comb begin
    IOBUS_IN = '0;
    if (w_hit) begin
      unique case (w_off)
        OFF_PENDING:  IOBUS_IN = 32'(r_pend);
        OFF_ENABLE:   IOBUS_IN = 32'(r_en);
        OFF_EDGE_SEL: IOBUS_IN = 32'(r_esel);
        OFF_CLAIM:    IOBUS_IN = 32'(prio_claim(w_act_x));
        OFF_STATUS:   IOBUS_IN = w_status;
        default:      IOBUS_IN = '0;
      endcase
    end
  end

  assign INTR = r_intr;

endmodule

// File: tb/tb_iobus_intr_ctrl.sv
// Directed bench for iobus_intr_ctrl with a cycle-level reference model.
// Model tracks source history and register state from the register-map rules.
module tb_iobus_intr_ctrl;

  localparam logic [31:0] BASE = 32'h1100_0200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  src = 8'h00;
  logic [31:0] addr = 32'h0;
  logic [31:0] dout = 32'h0;
  logic        wr = 1'b0;
  logic [31:0] IOBUS_IN;
  logic        INTR;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  iobus_intr_ctrl #(
    .N_SRC     (8),
    .BASE_ADDR (BASE),
    .EDGE_RST  (8'hFF)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .SRC        (src),
    .IOBUS_ADDR (addr),
    .IOBUS_OUT  (dout),
    .IOBUS_WR   (wr),
    .IOBUS_IN   (IOBUS_IN),
    .INTR       (INTR)
  );

  always #5 clk = ~clk;

  // Reference state: SRC samples from the last three edges plus registers.
  logic [7:0] p1, p2, p3;
  logic [7:0] m_pend, m_en, m_esel;
  logic       m_intr;

  always @(posedge clk or posedge rst) begin
    logic [7:0] set, clr, en_n, es_n;
    int k;
    if (rst) begin
      p1 = 0; p2 = 0; p3 = 0;
      m_pend = 0; m_en = 0; m_esel = 8'hFF; m_intr = 0;
    end else begin
      // Synchronized value is SRC from two edges back, prior one from three.
      for (int i = 0; i < 8; i++)
        set[i] = m_esel[i] ? (p2[i] && !p3[i]) : p2[i];
      clr = 0; en_n = m_en; es_n = m_esel;
      if (wr && addr[31:5] == BASE[31:5]) begin
        case (addr[4:2])
          3'd0: clr = dout[7:0];
          3'd1: en_n = dout[7:0];
          3'd2: es_n = dout[7:0];
          3'd3: begin
            k = int'(dout);
            if (dout <= 32'd8 && dout >= 32'd1) clr[k-1] = 1'b1;
          end
          default: ;
        endcase
      end
      m_pend = (m_pend & ~clr) | set;
      m_en = en_n;
      m_esel = es_n;
      m_intr = |(m_pend & m_en);
      p3 = p2; p2 = p1; p1 = src;
    end
  end

  function automatic logic [31:0] mread(input logic [31:0] a);
    logic [31:0] r;
    logic [7:0] act;
    r = 0;
    act = m_pend & m_en;
    if (a[31:5] == BASE[31:5]) begin
      case (a[4:2])
        3'd0: r = {24'h0, m_pend};
        3'd1: r = {24'h0, m_en};
        3'd2: r = {24'h0, m_esel};
        3'd3: begin
          for (int i = 0; i < 8 && r == 0; i++)
            if (act[i]) r = i + 1;
        end
        3'd4: r = ($countones(act) << 8) | {31'h0, m_intr};
        default: r = 0;
      endcase
    end
    return r;
  endfunction

  // Every cycle: INTR and the addressed read data against the model.
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (INTR !== m_intr) begin
        errors++;
        $display("FAIL model_intr got %b exp %b t=%0t", INTR, m_intr, $time);
      end
      checks++;
      if (IOBUS_IN !== mread(addr)) begin
        errors++;
        $display("FAIL model_rd addr %h got %h exp %h t=%0t",
                 addr, IOBUS_IN, mread(addr), $time);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    addr = a; dout = d; wr = 1'b1;
    cyc();
    wr = 1'b0;
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp,
                        input string nm);
    addr = a;
    @(negedge clk);
    #1;
    checks++;
    if (IOBUS_IN !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, IOBUS_IN, exp);
    end
    cyc();
  endtask

  task automatic intr_chk(input logic exp, input string nm);
    checks++;
    if (INTR !== exp) begin
      errors++;
      $display("FAIL %s intr got %b exp %b", nm, INTR, exp);
    end
  endtask

  initial begin
    #1;
    rst = 1'b1;
    src = 8'hFF;
    started = 1'b1;
    cyc();
    intr_chk(1'b0, "rst_intr");
    rd_chk(BASE + 32'h00, 32'h0, "rst_pend");
    rd_chk(BASE + 32'h04, 32'h0, "rst_en");
    rd_chk(BASE + 32'h08, 32'hFF, "rst_esel");
    rst = 1'b0;
    cyc(); cyc(); cyc();
    rd_chk(BASE + 32'h00, 32'hFF, "post_rst_pend");
    intr_chk(1'b0, "post_rst_intr");
    src = 8'h00;
    wr_reg(BASE + 32'h00, 32'hFF);
    rd_chk(BASE + 32'h00, 32'h0, "w1c_all");

    wr_reg(BASE + 32'h04, 32'h04);
    src = 8'h04;
    cyc();
    src = 8'h00;
    cyc();
    rd_chk(BASE + 32'h00, 32'h0, "lat_pend_early");
    rd_chk(BASE + 32'h00, 32'h04, "lat_pend");
    intr_chk(1'b1, "lat_intr");
    rd_chk(BASE + 32'h0C, 32'd3, "lat_claim");
    wr_reg(BASE + 32'h0C, 32'd3);
    intr_chk(1'b0, "claim_drop");
    rd_chk(BASE + 32'h00, 32'h0, "claim_pend");

    wr_reg(BASE + 32'h04, 32'hFF);
    src = 8'h22;
    cyc();
    src = 8'h00;
    cyc(); cyc();
    rd_chk(BASE + 32'h0C, 32'd2, "prio_claim");
    rd_chk(BASE + 32'h10, 32'h201, "prio_status");
    wr_reg(BASE + 32'h00, 32'h02);
    rd_chk(BASE + 32'h0C, 32'd6, "prio_claim2");
    rd_chk(BASE + 32'h10, 32'h101, "prio_status2");
    wr_reg(BASE + 32'h00, 32'hFF);

    wr_reg(BASE + 32'h08, 32'h00);
    wr_reg(BASE + 32'h04, 32'h01);
    src = 8'h01;
    cyc(); cyc(); cyc();
    rd_chk(BASE + 32'h00, 32'h01, "lvl_pend");
    wr_reg(BASE + 32'h00, 32'h01);
    rd_chk(BASE + 32'h00, 32'h01, "lvl_repend");
    intr_chk(1'b1, "lvl_intr_hold");
    src = 8'h00;
    cyc(); cyc();
    wr_reg(BASE + 32'h00, 32'h01);
    intr_chk(1'b0, "lvl_intr_drop");
    rd_chk(BASE + 32'h00, 32'h0, "lvl_pend_clr");

    wr_reg(BASE + 32'h08, 32'hFF);
    wr_reg(BASE + 32'h04, 32'h08);
    src = 8'h08;
    cyc();
    src = 8'h00;
    cyc();
    wr_reg(BASE + 32'h00, 32'h08);
    rd_chk(BASE + 32'h00, 32'h08, "collide_pend");
    intr_chk(1'b1, "collide_intr");

    wr_reg(BASE + 32'h14, 32'hFFFF_FFFF);
    wr_reg(BASE + 32'h20, 32'hFFFF_FFFF);
    rd_chk(BASE + 32'h14, 32'h0, "dec_hole");
    rd_chk(BASE + 32'h20, 32'h0, "dec_miss");
    rd_chk(BASE + 32'h04, 32'h08, "dec_en_keep");
    rd_chk(BASE + 32'h08, 32'hFF, "dec_esel_keep");
    rd_chk(BASE + 32'h00, 32'h08, "dec_pend_keep");
    wr_reg(BASE + 32'h06, 32'h11);
    rd_chk(BASE + 32'h04, 32'h11, "dec_lowbits");

    wr_reg(BASE + 32'h04, 32'h08);
    intr_chk(1'b1, "pre_rst_intr");
    #2;
    rst = 1'b1;
    #1;
    intr_chk(1'b0, "midrst_intr");
    cyc();
    rst = 1'b0;
    rd_chk(BASE + 32'h00, 32'h0, "midrst_pend");
    rd_chk(BASE + 32'h04, 32'h0, "midrst_en");
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
